// File: rtl/risc_mc_controller.sv
// Multi-cycle RV32I main controller: Moore sequencer driving datapath selects,
// write enables and ALU operation, with a sticky illegal flag and retire counter.
module risc_mc_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 en,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [2:0]           ALUControl,
    output logic [3:0]           state,
    output logic                 illegal,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    logic [3:0]           r_state;
    logic [3:0]           w_state_next;
    logic                 r_illegal;
    logic                 r_inst_bad;
    logic [INSTRET_W-1:0] r_instret;

    logic       w_op_known;
    logic       w_alu_bad;
    logic       w_br_bad;
    logic       w_in_exec;
    logic       w_set_illegal;
    logic       w_terminal;
    logic       w_retire;
    logic [2:0] w_alu_dec;

    logic       w_pcwrite;
    logic       w_adrsrc;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [2:0] w_alucontrol;

    always_comb begin
        w_op_known = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: w_op_known = 1'b1;
            default:                                                  w_op_known = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  w_alu_dec = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_dec = ALU_SLL;
            3'b100:  w_alu_dec = ALU_XOR;
            3'b101:  w_alu_dec = ALU_SRL;
            3'b110:  w_alu_dec = ALU_OR;
            3'b111:  w_alu_dec = ALU_AND;
            default: w_alu_dec = ALU_ADD;
        endcase
    end

    assign w_alu_bad     = (funct3 == 3'b010) || (funct3 == 3'b011);
    assign w_br_bad      = (funct3 != 3'b000) && (funct3 != 3'b001);
    assign w_in_exec     = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);
    assign w_set_illegal = en && (((r_state == S_DECODE) && !w_op_known) ||
                                  (w_in_exec && w_alu_bad) ||
                                  ((r_state == S_BEQ) && w_br_bad));

    // An instruction flagged illegal on the way still completes its sequence but never retires.
    assign w_terminal = (r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                        (r_state == S_ALUWB) || ((r_state == S_BEQ) && !w_br_bad);
    assign w_retire   = en && !areset && w_terminal && !r_inst_bad;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state    <= S_FETCH;
            r_illegal  <= 1'b0;
            r_inst_bad <= 1'b0;
            r_instret  <= '0;
        end else if (en) begin
            r_state <= w_state_next;
            if (w_set_illegal)
                r_illegal <= 1'b1;
            if (w_state_next == S_FETCH)
                r_inst_bad <= 1'b0;
            else if (w_in_exec && w_alu_bad)
                r_inst_bad <= 1'b1;
            if (w_retire)
                r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
                    OP_RTYPE:          w_state_next = S_EXECUTER;
                    OP_ITYPE:          w_state_next = S_EXECUTEI;
                    OP_BRANCH:         w_state_next = S_BEQ;
                    OP_JAL:            w_state_next = S_JAL;
                    default:           w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_state_next = S_MEMWB;
            S_EXECUTER: w_state_next = S_ALUWB;
            S_EXECUTEI: w_state_next = S_ALUWB;
            S_JAL:      w_state_next = S_ALUWB;
            default:    w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pcwrite    = 1'b0;
        w_adrsrc     = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_resultsrc  = 2'b00;
        w_alusrca    = 2'b00;
        w_alusrcb    = 2'b00;
        w_alucontrol = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_pcwrite   = 1'b1;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
            end
            S_MEMREAD:  w_adrsrc = 1'b1;
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTER: begin
                w_alusrca    = 2'b10;
                w_alucontrol = w_alu_dec;
            end
            S_EXECUTEI: begin
                w_alusrca    = 2'b10;
                w_alusrcb    = 2'b01;
                w_alucontrol = w_alu_dec;
            end
            S_ALUWB:    w_regwrite = 1'b1;
            S_BEQ: begin
                w_alusrca    = 2'b10;
                w_alucontrol = ALU_SUB;
                if (funct3 == 3'b000)
                    w_pcwrite = zero;
                else if (funct3 == 3'b001)
                    w_pcwrite = !zero;
            end
            S_JAL: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    // Strobes are qualified by en and by reset so a stall or reset never leaks a write.
    assign PCWrite    = w_pcwrite  && en && !areset;
    assign IRWrite    = w_irwrite  && en && !areset;
    assign RegWrite   = w_regwrite && en && !areset;
    assign MemWrite   = w_memwrite && en && !areset;
    assign AdrSrc     = w_adrsrc;
    assign ResultSrc  = w_resultsrc;
    assign ALUSrcA    = w_alusrca;
    assign ALUSrcB    = w_alusrcb;
    assign ALUControl = w_alucontrol;
    assign state      = r_state;
    assign illegal    = r_illegal;
    assign retire     = w_retire;
    assign instret    = r_instret;
endmodule

// File: tb/tb_risc_mc_controller.sv
// Randomized bench for risc_mc_controller against an instruction-level reference model.
module tb_risc_mc_controller;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         areset, en, funct7b5, zero;
    logic [6:0]   op;
    logic [2:0]   funct3;
    logic         PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, retire;
    logic [1:0]   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]   ALUControl;
    logic [3:0]   state;
    logic [W-1:0] instret;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned m_instret = 0;
    logic        m_illegal = 1'b0;

    always #5 clk = ~clk;

    risc_mc_controller #(.INSTRET_W(W)) dut (
        .clk(clk), .areset(areset), .en(en), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state(state),
        .illegal(illegal), .retire(retire), .instret(instret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit op_known(input logic [6:0] o);
        return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
               (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
    endfunction

    function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o == 7'b0110011 && f7) ? 3'b010 : 3'b000;
            3'd1:    return 3'b001;
            3'd4:    return 3'b100;
            3'd5:    return 3'b101;
            3'd6:    return 3'b110;
            3'd7:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Packed as {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
    function automatic logic [13:0] exp_ctrl(input int st, input logic [6:0] o, input logic [2:0] f3,
                                             input logic f7, input logic z, input logic e);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; rs = 0; sa = 0; sb = 0; alu = 0;
        case (st)
            0:  begin irw = 1; sb = 2; rs = 2; pcw = 1; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; alu = alu_of(o, f3, f7); end
            7:  rw = 1;
            8:  begin sa = 2; sb = 1; alu = alu_of(o, f3, f7); end
            9:  begin sa = 1; sb = 2; pcw = 1; end
            10: begin sa = 2; alu = 3'b010; pcw = (f3 == 0) ? z : (f3 == 1) ? !z : 1'b0; end
            default: ;
        endcase
        return {pcw & e, adr, mw & e, irw & e, rw & e, rs, sa, sb, alu};
    endfunction

    // One instruction from FETCH back to FETCH; zfix<0 randomizes zero, stall_at inserts 3 stalls.
    task automatic run_instr(input logic [6:0] iop, input logic [2:0] if3, input logic if7,
                             input int zfix, input int stall_pct, input int stall_at);
        int seq[$];
        int det, idx, cyc, stalled, last;
        bit ret;
        det = -1;
        case (iop)
            7'b0000011: seq = '{0, 1, 2, 3, 4};
            7'b0100011: seq = '{0, 1, 2, 5};
            7'b0110011: begin seq = '{0, 1, 6, 7}; if (if3 == 2 || if3 == 3) det = 2; end
            7'b0010011: begin seq = '{0, 1, 8, 7}; if (if3 == 2 || if3 == 3) det = 2; end
            7'b1100011: begin seq = '{0, 1, 10};   if (if3 > 1) det = 2; end
            7'b1101111: seq = '{0, 1, 9, 7};
            default:    begin seq = '{0, 1}; det = 1; end
        endcase
        ret = (det < 0);
        last = seq.size() - 1;
        op = iop; funct3 = if3; funct7b5 = if7;
        idx = 0; cyc = 0; stalled = 0;
        while (idx <= last && cyc < 300) begin
            cyc++;
            if (seq[idx] == stall_at && stalled < 3) begin
                en = 1'b0;
                stalled++;
            end else begin
                en = ($urandom_range(99) >= stall_pct);
            end
            zero = (zfix >= 0) ? zfix[0] : 1'($urandom_range(1));
            @(negedge clk);
            check("state", 32'(state), 32'(seq[idx]));
            check("ctrl", 32'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}),
                  32'(exp_ctrl(seq[idx], iop, if3, if7, zero, en)));
            check("immsrc", 32'(ImmSrc), 32'(imm_of(iop)));
            check("illegal", 32'(illegal), 32'(m_illegal));
            check("instret", instret, m_instret);
            check("retire", 32'(retire), 32'(en && ret && idx == last));
            @(posedge clk);
            #1;
            if (en) begin
                if (idx == det) m_illegal = 1'b1;
                if (idx == last && ret) m_instret++;
                idx++;
            end
        end
        if (cyc >= 300) check("timeout", 32'd1, 32'd0);
        $display("instr op=%b f3=%0d f7=%0d cycles=%0d instret=%0d illegal=%0d", iop, if3, if7, cyc, instret, illegal);
    endtask

    initial begin
        logic [6:0] rop;
        logic [6:0] ops [6];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        areset = 1'b1; en = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        en = 1'b1;
        #1;
        check("rst_we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Directed cases
        run_instr(7'b0000011, 3'd2, 1'b0, -1, 0, -1);
        run_instr(7'b0110011, 3'd0, 1'b1, -1, 0, -1);
        run_instr(7'b0010011, 3'd0, 1'b1, -1, 0, -1);
        run_instr(7'b1100011, 3'd0, 1'b0, 1, 0, -1);
        run_instr(7'b1100011, 3'd1, 1'b0, 1, 0, -1);
        run_instr(7'b0100011, 3'd2, 1'b0, -1, 0, 5);

        // Randomized mix with stalls
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(99) < 5) begin
                do rop = 7'($urandom_range(127)); while (op_known(rop));
            end else begin
                rop = ops[$urandom_range(5)];
            end
            run_instr(rop, 3'($urandom_range(7)), 1'($urandom_range(1)), -1, 20, -1);
        end

        run_instr(7'b1111111, 3'd0, 1'b0, -1, 0, -1);
        run_instr(7'b0110011, 3'd7, 1'b0, -1, 0, -1);

        // Asynchronous reset while in MEMADR
        op = 7'b0000011; en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_state", 32'(state), 32'd2);
        #2;
        areset = 1'b1;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        check("async_instret", instret, 32'd0);
        check("async_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        check("held_state", 32'(state), 32'd0);
        areset = 1'b0;
        m_instret = 0;
        m_illegal = 1'b0;
        run_instr(7'b0000011, 3'd2, 1'b0, -1, 0, -1);
        run_instr(7'b1101111, 3'd0, 1'b0, -1, 10, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
